// File: rtl/output_port_allocator.sv
// Packet-granular round-robin allocator for one router output port shared by five inputs.
// Optional stall timeout with forced release: define ARB_TIMEOUT_EN.
module output_port_allocator #(
  parameter int                NPORTS   = 5,
  parameter int                FID_W    = 3,
  parameter logic [FID_W-1:0]  HEAD_ID  = 3'b001,
  parameter logic [FID_W-1:0]  TAIL_ID  = 3'b100,
  parameter int                CNT_W    = 12,
  parameter logic [CNT_W-1:0]  MAX_WAIT = 12'd64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       req,
  input  logic [NPORTS*FID_W-1:0] flit_id,
  input  logic                    out_ready,
  output logic [NPORTS-1:0]       grant,
  output logic [2:0]              sel,
  output logic                    busy,
  output logic                    xfer,
  output logic                    timeout
);

  localparam logic [2:0] SEL_IDLE = 3'b111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [NPORTS-1:0] grant_nxt;
  logic [2:0]        sel_nxt;
  logic              busy_nxt;
  logic [2:0]        rr_ptr, rr_ptr_nxt;
  logic [NPORTS-1:0] eligible;
  logic [FID_W-1:0]  cur_fid;
  logic              tail_xfer;
  logic              stall_expire;
  logic              found;
  logic [2:0]        pick_idx;
  logic [2:0]        ptr_base;
  logic [2:0]        sel_inc;
  int                scan_p;

  assign xfer      = |(grant & req) & out_ready;
  assign tail_xfer = xfer && (cur_fid == TAIL_ID);

  // Flit id of the granted port, muxed by the one-hot grant so an idle sel never indexes.
  always_comb begin
    eligible = '0;
    cur_fid  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      eligible[i] = req[i] && (flit_id[i*FID_W +: FID_W] == HEAD_ID);
      if (grant[i]) cur_fid = cur_fid | flit_id[i*FID_W +: FID_W];
    end
  end

  // Round-robin scan starting at rr_ptr; out-of-range pointers restart at port 0.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    scan_p   = 0;
    ptr_base = (int'(rr_ptr) < NPORTS) ? rr_ptr : 3'd0;
    for (int k = 0; k < NPORTS; k++) begin
      scan_p = int'(ptr_base) + k;
      if (scan_p >= NPORTS) scan_p = scan_p - NPORTS;
      if (!found && eligible[scan_p]) begin
        found    = 1'b1;
        pick_idx = 3'(scan_p);
      end
    end
  end

  assign sel_inc = (int'(sel) >= NPORTS - 1) ? 3'd0 : 3'(sel + 3'd1);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] stall_cnt;

  assign stall_expire = (state == BUSY) && !xfer && (stall_cnt == MAX_WAIT - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= stall_expire && !tail_xfer;
      if (state != BUSY || xfer || stall_expire) stall_cnt <= '0;
      else                                       stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_expire = 1'b0;
  assign timeout      = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    sel_nxt    = sel;
    busy_nxt   = busy;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = NPORTS'(1) << pick_idx;
          sel_nxt   = pick_idx;
          busy_nxt  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A tail on the final stall cycle is a normal release; the timeout pulse is suppressed.
        if (tail_xfer || stall_expire) begin
          grant_nxt  = '0;
          sel_nxt    = SEL_IDLE;
          busy_nxt   = 1'b0;
          rr_ptr_nxt = sel_inc;
          state_nxt  = IDLE;
        end
      end
      default: begin
        grant_nxt  = '0;
        sel_nxt    = SEL_IDLE;
        busy_nxt   = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      sel    <= SEL_IDLE;
      busy   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      sel    <= sel_nxt;
      busy   <= busy_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed self-checking bench for output_port_allocator; covers ARB_TIMEOUT_EN when defined.
module tb_output_port_allocator;

  localparam int NPORTS = 5;
  localparam int FID_W  = 3;
  localparam logic [2:0] HEAD = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;
`ifdef ARB_TIMEOUT_EN
  localparam int MW = 8;
  localparam int BP = 6;
`else
  localparam int MW = 64;
  localparam int BP = 10;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NPORTS-1:0]       req;
  logic [NPORTS*FID_W-1:0] flit_id;
  logic                    out_ready;
  logic [NPORTS-1:0]       grant;
  logic [2:0]              sel;
  logic                    busy;
  logic                    xfer;
  logic                    timeout;

  int checks = 0;
  int errors = 0;
  int nx;

  output_port_allocator #(.MAX_WAIT(12'(MW))) dut (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .out_ready(out_ready),
    .grant(grant), .sel(sel), .busy(busy), .xfer(xfer), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_fid(input int p, input logic [2:0] v);
    flit_id[p*FID_W +: FID_W] = v;
  endtask

  task automatic all_head();
    for (int i = 0; i < NPORTS; i++) set_fid(i, HEAD);
  endtask

  initial begin
    rst = 1'b1; req = '0; flit_id = '0; out_ready = 1'b1;
    #3;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sel", 32'(sel), 32'h7);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_after_rst", 32'(busy), 32'h0);

    // Body flit at an unserved port must not win a grant.
    req = 5'b00001; set_fid(0, BODY);
    tick();
    check("nonhead_ignored", 32'(grant), 32'h0);

    // Single 4-flit packet from N.
    req = 5'b00010; flit_id = '0; set_fid(1, HEAD);
    #1 check("pre_grant_xfer", 32'(xfer), 32'h0);
    tick();
    check("single_grant", 32'(grant), 32'h02);
    check("single_sel", 32'(sel), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    nx = 0;
    for (int f = 0; f < 4; f++) begin
      set_fid(1, (f == 0) ? HEAD : (f == 3) ? TAIL : BODY);
      #1 if (xfer) nx++;
      tick();
    end
    check("single_xfer_cnt", 32'(nx), 32'd4);
    check("single_rel_grant", 32'(grant), 32'h0);
    check("single_rel_sel", 32'(sel), 32'h7);
    check("single_rel_busy", 32'(busy), 32'h0);

    // rr_ptr now 2: with all eligible, E wins; then reset mid-packet.
    req = 5'b11111; all_head();
    tick();
    check("rr_ptr_2", 32'(grant), 32'h04);
    #1 rst = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_sel", 32'(sel), 32'h7);
    check("midrst_busy", 32'(busy), 32'h0);
    req = '0;
    tick();
    rst = 1'b0;
    tick(); tick();
    check("post_rst_idle", 32'(grant), 32'h0);

    // Round-robin over continuous 2-flit packets: L,N,E,W,S,L with a bubble after each.
    req = 5'b11111; all_head();
    for (int k = 0; k < 18; k++) begin
      int pkt;
      int ph;
      logic [NPORTS-1:0] eg;
      pkt = k / 3;
      ph  = k % 3;
      eg  = (ph < 2) ? (NPORTS'(1) << (pkt % NPORTS)) : '0;
      tick();
      check("rr_grant", 32'(grant), 32'(eg));
      all_head();
      if (ph == 1) set_fid(pkt % NPORTS, TAIL);
      #1 check("rr_xfer", 32'(xfer), (ph < 2) ? 32'h1 : 32'h0);
    end
    req = '0;
    tick();
    check("rr_done_idle", 32'(busy), 32'h0);

    // Hold: E granted, W waits while E stalls with req dropped.
    req = 5'b01100; set_fid(2, HEAD); set_fid(3, HEAD);
    tick();
    check("hold_grant_e", 32'(grant), 32'h04);
    tick();
    req = 5'b01000; set_fid(2, BODY);
    for (int s = 0; s < 3; s++) begin
      #1 check("hold_xfer0", 32'(xfer), 32'h0);
      tick();
      check("hold_grant", 32'(grant), 32'h04);
    end
    req = 5'b01100; set_fid(2, TAIL);
    #1 check("hold_tail_xfer", 32'(xfer), 32'h1);
    tick();
    check("hold_bubble", 32'(grant), 32'h0);
    tick();
    check("hold_grant_w", 32'(grant), 32'h08);
    tick();
    set_fid(3, TAIL);
    tick();
    check("hold_w_rel", 32'(grant), 32'h0);
    req = '0;

    // Backpressure on S mid-packet.
    req = 5'b10000; set_fid(4, HEAD);
    tick();
    check("bp_grant", 32'(grant), 32'h10);
    nx = 0;
    #1 if (xfer) nx++;
    tick();
    set_fid(4, BODY); out_ready = 1'b0;
    for (int s = 0; s < BP; s++) begin
      #1 check("bp_xfer0", 32'(xfer), 32'h0);
      if (xfer) nx++;
      tick();
      check("bp_hold", 32'(grant), 32'h10);
    end
    out_ready = 1'b1;
    #1 if (xfer) nx++;
    tick();
    set_fid(4, TAIL);
    #1 if (xfer) nx++;
    tick();
    check("bp_xfer_cnt", 32'(nx), 32'd3);
    check("bp_rel", 32'(grant), 32'h0);
    req = '0;

    // Stall: L granted then drops req while N waits with a header.
    req = 5'b00001; set_fid(0, HEAD);
    tick();
    check("stall_grant_l", 32'(grant), 32'h01);
    tick();
    req = 5'b00010; set_fid(0, BODY); set_fid(1, HEAD);
`ifdef ARB_TIMEOUT_EN
    for (int s = 0; s < MW - 1; s++) tick();
    check("to_pre_grant", 32'(grant), 32'h01);
    check("to_pre_pulse", 32'(timeout), 32'h0);
    tick();
    check("to_release", 32'(grant), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    tick();
    check("to_next_grant", 32'(grant), 32'h02);
    check("to_pulse_end", 32'(timeout), 32'h0);
    tick();
    set_fid(1, TAIL);
    tick();
    check("to_n_rel", 32'(grant), 32'h0);
`else
    for (int s = 0; s < 12; s++) tick();
    check("noto_hold", 32'(grant), 32'h01);
    check("noto_timeout", 32'(timeout), 32'h0);
    req = 5'b00011; set_fid(0, TAIL);
    #1 check("noto_tail_xfer", 32'(xfer), 32'h1);
    tick();
    check("noto_rel", 32'(grant), 32'h0);
    tick();
    check("noto_next_grant", 32'(grant), 32'h02);
    tick();
    set_fid(1, TAIL);
    tick();
    check("noto_n_rel", 32'(grant), 32'h0);
`endif
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
